// File: rtl/mem_access.sv
// Memory-access stage: classifies execute-side ops, drives a req/gnt/rvalid
// data-memory port for legal loads/stores and registers the writeback result.
module mem_access #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instruction_i,
   input  logic [XLEN-1:0] alu_data_i,
   input  logic [XLEN-1:0] memory_write_data_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            rd_write_enable_i,
   input  logic            memory_write_enable_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [3:0]      dmem_be_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instruction_o,
   output logic [4:0]      rd_addr_o,
   output logic            rd_write_enable_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            misaligned_o
);

   typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

   state_e          state_q, state_d;
   // request fields latched at acceptance, held until completion
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            is_store_q, is_store_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [1:0]      off_q, off_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d, pend_instr_q, pend_instr_d;
   logic [4:0]      pend_rd_q, pend_rd_d;
   logic            pend_rd_we_q, pend_rd_we_d;
   // writeback registers
   logic            valid_q, valid_d, rd_we_q, rd_we_d, mis_q, mis_d;
   logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, rd_data_q, rd_data_d;
   logic [4:0]      rd_addr_q, rd_addr_d;

   logic            accept, is_store, is_load, misaligned, unsupported;
   logic [2:0]      f3;
   logic [1:0]      off;
   logic [XLEN-1:0] st_wdata, ld_data;
   logic [3:0]      st_be;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;

   assign f3       = instruction_i[14:12];
   assign off      = alu_data_i[1:0];
   assign accept   = valid_i && (state_q == StIdle);
   assign is_store = memory_write_enable_i;
   assign is_load  = !memory_write_enable_i && (instruction_i[6:0] == 7'b0000011);

   // classify the incoming op and build store lanes
   always_comb begin
      misaligned  = 1'b0;
      unsupported = 1'b0;
      if (is_store) begin
         case (f3)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = off[0];
            3'd2:    misaligned = (off != 2'b00);
            default: unsupported = 1'b1;
         endcase
      end else if (is_load) begin
         case (f3)
            3'd0, 3'd4: misaligned = 1'b0;
            3'd1, 3'd5: misaligned = off[0];
            3'd2:       misaligned = (off != 2'b00);
            default:    unsupported = 1'b1;
         endcase
      end
      case (f3[1:0])
         2'd0: begin
            st_wdata = {(XLEN/8){memory_write_data_i[7:0]}};
            st_be    = 4'b0001 << off;
         end
         2'd1: begin
            st_wdata = {(XLEN/16){memory_write_data_i[15:0]}};
            st_be    = 4'b0011 << off;
         end
         default: begin
            st_wdata = memory_write_data_i;
            st_be    = 4'b1111;
         end
      endcase
   end

   // extract and extend load data from the returned word
   always_comb begin
      ld_byte = dmem_rdata_i[{off_q, 3'b000} +: 8];
      // legal halfword offsets are 0 or 2, so only off_q[1] matters
      ld_half = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'd0:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'd1:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'd4:    ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'd5:    ld_data = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_data = dmem_rdata_i;
      endcase
   end

   // next-state and register updates for FSM, request latch and writeback
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      is_store_d   = is_store_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      pend_pc_d    = pend_pc_q;
      pend_instr_d = pend_instr_q;
      pend_rd_d    = pend_rd_q;
      pend_rd_we_d = pend_rd_we_q;
      valid_d      = 1'b0;
      pc_d         = pc_q;
      instr_d      = instr_q;
      rd_addr_d    = rd_addr_q;
      rd_we_d      = rd_we_q;
      rd_data_d    = rd_data_q;
      mis_d        = mis_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if ((is_load || is_store) && !misaligned && !unsupported) begin
                  state_d      = StWaitGnt;
                  addr_d       = {alu_data_i[XLEN-1:2], 2'b00};
                  wdata_d      = is_store ? st_wdata : '0;
                  be_d         = is_store ? st_be : 4'b1111;
                  is_store_d   = is_store;
                  funct3_d     = f3;
                  off_d        = off;
                  pend_pc_d    = pc_i;
                  pend_instr_d = instruction_i;
                  pend_rd_d    = rd_addr_i;
                  pend_rd_we_d = rd_write_enable_i;
               end else begin
                  // pass-through, misaligned or unsupported: retire next cycle
                  valid_d   = 1'b1;
                  pc_d      = pc_i;
                  instr_d   = instruction_i;
                  rd_addr_d = rd_addr_i;
                  rd_data_d = alu_data_i;
                  rd_we_d   = (is_load || is_store) ? 1'b0 : rd_write_enable_i;
                  mis_d     = (is_load || is_store) && misaligned;
               end
            end
         end
         StWaitGnt: begin
            if (dmem_gnt_i) begin
               state_d = StWaitRvalid;
            end
         end
         StWaitRvalid: begin
            if (dmem_rvalid_i) begin
               state_d   = StIdle;
               valid_d   = 1'b1;
               pc_d      = pend_pc_q;
               instr_d   = pend_instr_q;
               rd_addr_d = pend_rd_q;
               rd_we_d   = is_store_q ? 1'b0 : pend_rd_we_q;
               rd_data_d = is_store_q ? '0 : ld_data;
               mis_d     = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // state registers, asynchronously cleared
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         is_store_q   <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         pend_pc_q    <= '0;
         pend_instr_q <= '0;
         pend_rd_q    <= '0;
         pend_rd_we_q <= 1'b0;
         valid_q      <= 1'b0;
         pc_q         <= '0;
         instr_q      <= '0;
         rd_addr_q    <= '0;
         rd_we_q      <= 1'b0;
         rd_data_q    <= '0;
         mis_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         is_store_q   <= is_store_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         pend_pc_q    <= pend_pc_d;
         pend_instr_q <= pend_instr_d;
         pend_rd_q    <= pend_rd_d;
         pend_rd_we_q <= pend_rd_we_d;
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         rd_addr_q    <= rd_addr_d;
         rd_we_q      <= rd_we_d;
         rd_data_q    <= rd_data_d;
         mis_q        <= mis_d;
      end
   end

   assign ready_o           = (state_q == StIdle);
   assign dmem_req_o        = (state_q == StWaitGnt);
   assign dmem_we_o         = dmem_req_o && is_store_q;
   assign dmem_be_o         = dmem_req_o ? be_q : 4'b0000;
   assign dmem_addr_o       = addr_q;
   assign dmem_wdata_o      = wdata_q;
   assign valid_o           = valid_q;
   assign pc_o              = pc_q;
   assign instruction_o     = instr_q;
   assign rd_addr_o         = rd_addr_q;
   assign rd_write_enable_o = rd_we_q;
   assign rd_data_o         = rd_data_q;
   assign misaligned_o      = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: an architectural model predicts each op's
// memory request and writeback; a negedge process compares every cycle.
module tb_mem_access;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i, ready_o;
   logic [31:0] pc_i, instruction_i, alu_data_i, memory_write_data_i;
   logic [4:0]  rd_addr_i;
   logic        rd_write_enable_i, memory_write_enable_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        valid_o;
   logic [31:0] pc_o, instruction_o, rd_data_o;
   logic [4:0]  rd_addr_o;
   logic        rd_write_enable_o, misaligned_o;

   mem_access #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .pc_i(pc_i), .instruction_i(instruction_i), .alu_data_i(alu_data_i),
      .memory_write_data_i(memory_write_data_i), .rd_addr_i(rd_addr_i),
      .rd_write_enable_i(rd_write_enable_i), .memory_write_enable_i(memory_write_enable_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
      .pc_o(pc_o), .instruction_o(instruction_o), .rd_addr_o(rd_addr_o),
      .rd_write_enable_o(rd_write_enable_o), .rd_data_o(rd_data_o),
      .misaligned_o(misaligned_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        is_mem;
      logic        misaligned;
      logic        rd_we;
      logic        data_chk;
      logic [31:0] rd_data;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   logic        chk_en = 1'b0;
   logic        exp_ready, exp_valid, exp_req;
   exp_t        exp_cur;
   logic [31:0] exp_pc, exp_instr;
   logic [4:0]  exp_rd;
   logic        lit_addr_en = 1'b0, lit_st_en = 1'b0, lit_data_en = 1'b0;
   logic [31:0] lit_addr, lit_wdata, lit_data;
   logic [3:0]  lit_be;
   logic [31:0] pc_cnt = 32'h0000_1000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model: what the op must do, from size/offset arithmetic
   function automatic exp_t model(input logic [31:0] instr, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic mwe, input logic rdwe,
                                  input logic [31:0] rdata);
      exp_t        e;
      int          f3, off, size;
      logic        store, load, legal;
      logic [31:0] mask, v;
      f3 = int'(instr[14:12]);
      off = int'(addr % 4);
      store = mwe;
      load = !mwe && (instr[6:0] == 7'b0000011);
      size = 1 << (f3 % 4);
      legal = store ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      e.is_mem = 1'b0; e.misaligned = 1'b0; e.rd_we = 1'b0; e.data_chk = 1'b0;
      e.rd_data = 32'h0; e.addr = addr - 32'(off); e.be = 4'h0; e.wdata = 32'h0; e.we = store;
      if (!(load || store)) begin
         e.rd_we = rdwe; e.rd_data = addr; e.data_chk = 1'b1;
         return e;
      end
      if (!legal) return e;
      if ((off % size) != 0) begin
         e.misaligned = 1'b1;
         return e;
      end
      e.is_mem = 1'b1;
      e.be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      if (load) begin
         mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
         v = (rdata >> (8 * off)) & mask;
         if (f3 < 4 && size < 4 && v[8*size-1]) v = v | ~mask;
         e.rd_data = v; e.data_chk = 1'b1; e.rd_we = rdwe;
      end
      return e;
   endfunction

   // Per-cycle comparison against the driver's expectations
   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("ready_o", {31'b0, ready_o}, {31'b0, exp_ready});
         chk("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
         chk("dmem_req_o", {31'b0, dmem_req_o}, {31'b0, exp_req});
         if (exp_req) begin
            chk("dmem_addr_o", dmem_addr_o, exp_cur.addr);
            chk("dmem_we_o", {31'b0, dmem_we_o}, {31'b0, exp_cur.we});
            if (exp_cur.we) begin
               chk("dmem_be_o", {28'b0, dmem_be_o}, {28'b0, exp_cur.be});
               chk("dmem_wdata_o", dmem_wdata_o, exp_cur.wdata);
            end
            if (lit_addr_en) chk("lit_addr", dmem_addr_o, lit_addr);
            if (lit_st_en) begin
               chk("lit_be", {28'b0, dmem_be_o}, {28'b0, lit_be});
               chk("lit_wdata", dmem_wdata_o, lit_wdata);
            end
         end else begin
            chk("dmem_we_idle", {31'b0, dmem_we_o}, 32'h0);
            chk("dmem_be_idle", {28'b0, dmem_be_o}, 32'h0);
         end
         if (exp_valid) begin
            chk("pc_o", pc_o, exp_pc);
            chk("instruction_o", instruction_o, exp_instr);
            chk("rd_addr_o", {27'b0, rd_addr_o}, {27'b0, exp_rd});
            chk("rd_write_enable_o", {31'b0, rd_write_enable_o}, {31'b0, exp_cur.rd_we});
            chk("misaligned_o", {31'b0, misaligned_o}, {31'b0, exp_cur.misaligned});
            if (exp_cur.data_chk) chk("rd_data_o", rd_data_o, exp_cur.rd_data);
            if (lit_data_en) chk("lit_rd_data", rd_data_o, lit_data);
         end
      end
   end

   // One op from acceptance to the cycle after its writeback appears
   task automatic run_op(input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic mwe, input logic [4:0] rd,
                         input logic rdwe, input logic [31:0] rdata, input int gnt_dly,
                         input int rv_dly, input logic gnt_rv_same);
      exp_t e;
      e = model(instr, addr, wd, mwe, rdwe, rdata);
      pc_cnt = pc_cnt + 32'd4;
      valid_i = 1'b1; pc_i = pc_cnt; instruction_i = instr; alu_data_i = addr;
      memory_write_data_i = wd; memory_write_enable_i = mwe; rd_addr_i = rd;
      rd_write_enable_i = rdwe;
      exp_valid = 1'b0; exp_ready = 1'b1; exp_req = 1'b0; exp_cur = e;
      @(posedge clk_i); #1;
      // scramble inputs so only latched values can be correct
      valid_i = 1'b0; instruction_i = 32'hFFFF_FFFF; alu_data_i = 32'h5A5A_5A5B;
      memory_write_data_i = 32'h1357_9BDF; rd_addr_i = 5'd31; memory_write_enable_i = 1'b0;
      if (e.is_mem) begin
         exp_ready = 1'b0; exp_req = 1'b1;
         for (int i = 0; i <= gnt_dly; i++) begin
            dmem_gnt_i = (i == gnt_dly);
            dmem_rvalid_i = (i == gnt_dly) && gnt_rv_same;
            dmem_rdata_i = 32'hDEAD_BEEF;
            @(posedge clk_i); #1;
         end
         dmem_gnt_i = 1'b0; exp_req = 1'b0;
         for (int j = 0; j <= rv_dly; j++) begin
            dmem_rvalid_i = (j == rv_dly);
            dmem_rdata_i = (j == rv_dly) ? rdata : 32'hDEAD_BEEF;
            @(posedge clk_i); #1;
         end
         dmem_rvalid_i = 1'b0;
      end
      exp_valid = 1'b1; exp_ready = 1'b1; exp_pc = pc_cnt; exp_instr = instr; exp_rd = rd;
      @(posedge clk_i); #1;
      exp_valid = 1'b0;
      lit_addr_en = 1'b0; lit_st_en = 1'b0; lit_data_en = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {31'b0, ready_o}, 32'h1);
      chk({tag, "_valid"}, {31'b0, valid_o}, 32'h0);
      chk({tag, "_req"}, {31'b0, dmem_req_o}, 32'h0);
      chk({tag, "_we"}, {31'b0, dmem_we_o}, 32'h0);
      chk({tag, "_be"}, {28'b0, dmem_be_o}, 32'h0);
      chk({tag, "_addr"}, dmem_addr_o, 32'h0);
      chk({tag, "_wdata"}, dmem_wdata_o, 32'h0);
      chk({tag, "_mis"}, {31'b0, misaligned_o}, 32'h0);
      chk({tag, "_rdwe"}, {31'b0, rd_write_enable_o}, 32'h0);
      chk({tag, "_rd_data"}, rd_data_o, 32'h0);
      chk({tag, "_pc"}, pc_o, 32'h0);
   endtask

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; pc_i = 32'h0; instruction_i = 32'h0; alu_data_i = 32'h0;
      memory_write_data_i = 32'h0; rd_addr_i = 5'd0; rd_write_enable_i = 1'b0;
      memory_write_enable_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      dmem_rdata_i = 32'h0;
      #3;
      chk_all_zero("reset");
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b0;
      exp_valid = 1'b0; exp_ready = 1'b1; exp_req = 1'b0;
      chk_en = 1'b1;

      // ADDI pass-through
      lit_data_en = 1'b1; lit_data = 32'h0000_1234;
      run_op(32'h1230_0293, 32'h0000_1234, 32'h0, 1'b0, 5'd5, 1'b1, 32'h0, 0, 0, 1'b0);
      // LB 0x103, fastest handshake
      lit_addr_en = 1'b1; lit_addr = 32'h0000_0100;
      lit_data_en = 1'b1; lit_data = 32'hFFFF_FF80;
      run_op(32'h0000_0303, 32'h0000_0103, 32'h0, 1'b0, 5'd6, 1'b1, 32'h80FF_0000, 0, 0, 1'b0);
      // SH 0x202
      lit_st_en = 1'b1; lit_be = 4'b1100; lit_wdata = 32'hABCD_ABCD;
      run_op(32'h0000_1023, 32'h0000_0202, 32'h0000_ABCD, 1'b1, 5'd0, 1'b1, 32'h0, 1, 2, 1'b0);
      // LW 0x201 misaligned
      run_op(32'h0000_2383, 32'h0000_0201, 32'h0, 1'b0, 5'd7, 1'b1, 32'h0, 0, 0, 1'b0);
      // LHU 0x0 with grant held off for 4 cycles
      lit_data_en = 1'b1; lit_data = 32'h0000_F00D;
      run_op(32'h0000_5403, 32'h0000_0000, 32'h0, 1'b0, 5'd8, 1'b1, 32'h1234_F00D, 4, 1, 1'b0);
      // LBU offset 2, rvalid alongside gnt must not complete
      run_op(32'h0000_4483, 32'h0000_0502, 32'h0, 1'b0, 5'd9, 1'b1, 32'h00AB_0000, 0, 0, 1'b1);
      // LH offset 2, negative
      run_op(32'h0000_1503, 32'h0000_0602, 32'h0, 1'b0, 5'd10, 1'b1, 32'h8001_0000, 2, 0, 1'b0);
      // LW aligned, rd write disabled
      run_op(32'h0000_2583, 32'h0000_0300, 32'h0, 1'b0, 5'd11, 1'b0, 32'hCAFE_BABE, 0, 3, 1'b0);
      // SB offset 3
      run_op(32'h0000_0023, 32'h0000_0003, 32'h1234_5678, 1'b1, 5'd1, 1'b1, 32'h0, 0, 0, 1'b1);
      // SW aligned
      run_op(32'h0000_2023, 32'h0000_0400, 32'hDEAD_C0DE, 1'b1, 5'd2, 1'b1, 32'h0, 1, 1, 1'b0);
      // SH misaligned, LHU misaligned
      run_op(32'h0000_1023, 32'h0000_0201, 32'h0000_1111, 1'b1, 5'd3, 1'b1, 32'h0, 0, 0, 1'b0);
      run_op(32'h0000_5403, 32'h0000_0003, 32'h0, 1'b0, 5'd12, 1'b1, 32'h0, 0, 0, 1'b0);
      // unsupported load funct3=3 and store funct3=5
      run_op(32'h0000_3603, 32'h0000_0700, 32'h0, 1'b0, 5'd12, 1'b1, 32'h0, 0, 0, 1'b0);
      run_op(32'h0000_5023, 32'h0000_0704, 32'h0, 1'b1, 5'd13, 1'b1, 32'h0, 0, 0, 1'b0);
      // branch-like pass-through with no register write
      run_op(32'h0000_0063, 32'h0000_0055, 32'h0, 1'b0, 5'd14, 1'b0, 32'h0, 0, 0, 1'b0);

      // Reset while waiting for rvalid, then a stray rvalid in idle
      chk_en = 1'b0;
      valid_i = 1'b1; instruction_i = 32'h0000_2383; alu_data_i = 32'h0000_0300;
      memory_write_enable_i = 1'b0; rd_addr_i = 5'd7; rd_write_enable_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0; dmem_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      dmem_gnt_i = 1'b0;
      chk("pre_rst_ready", {31'b0, ready_o}, 32'h0);
      #1 rst_i = 1'b1;
      #1 chk_all_zero("mid_rst");
      #1 rst_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
      @(posedge clk_i); #1;
      dmem_rvalid_i = 1'b0;
      chk_all_zero("post_rst");
      @(posedge clk_i); #1;
      chk_all_zero("post_rst2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
